// File: rtl/dmem_responder_if.sv
// Load/store handshake between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  fnc3;
  logic [31:0] Mout;
  logic        stall;
  logic        misalign;

  modport master (
    output memRead, memWrite, addr, wdata, fnc3,
    input  Mout, stall, misalign
  );

  modport slave (
    input  memRead, memWrite, addr, wdata, fnc3,
    output Mout, stall, misalign
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency RV32I load/store servicing with byte/half sizing,
// sign extension and misalignment detection; drives Mout/stall into MEM/WB.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      fnc3_q, fnc3_d;
  logic            store_q, store_d;
  logic [31:0]     mout_q, mout_d;
  logic            mis_q, mis_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            req;
  logic            stall_c;
  logic            mem_we;
  logic [AW-1:0]   word_idx;
  logic [1:0]      lane;
  logic [31:0]     rdata;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [31:0]     load_val;
  logic            mis_c;
  logic [3:0]      be;
  logic [31:0]     wd_lanes;

  assign req      = bus.memRead | bus.memWrite;
  assign word_idx = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign rdata    = mem_q[word_idx];
  assign sel_byte = rdata[8*lane +: 8];
  assign sel_half = addr_q[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_val = '0;
    case (fnc3_q)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_val = {16'd0, sel_half};
      3'b010:  load_val = rdata;
      default: load_val = '0;
    endcase
  end

  // 101 is LHU for loads but has no store meaning, so it only counts as a halfword on loads.
  always_comb begin
    mis_c = 1'b0;
    case (fnc3_q)
      3'b001:  mis_c = addr_q[0];
      3'b101:  mis_c = ~store_q & addr_q[0];
      3'b010:  mis_c = (addr_q[1:0] != 2'b00);
      default: mis_c = 1'b0;
    endcase
  end

  always_comb begin
    be       = '0;
    wd_lanes = wdata_q;
    case (fnc3_q)
      3'b000: begin
        be       = 4'b0001 << lane;
        wd_lanes = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        be       = 4'b1111;
        wd_lanes = wdata_q;
      end
      default: be = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fnc3_d  = fnc3_q;
    store_d = store_q;
    mout_d  = mout_q;
    mis_d   = 1'b0;
    mem_we  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = req;
        if (req) begin
          addr_d  = bus.addr[AW+1:0];
          wdata_d = bus.wdata;
          fnc3_d  = bus.fnc3;
          store_d = bus.memWrite;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
          mis_d   = mis_c;
          if (store_q) begin
            mem_we = ~mis_c;
          end else begin
            mout_d = mis_c ? '0 : load_val;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      fnc3_q  <= '0;
      store_q <= 1'b0;
      mout_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fnc3_q  <= fnc3_d;
      store_q <= store_d;
      mout_q  <= mout_d;
      mis_q   <= mis_d;
    end
  end

  // Array is never cleared; gating on rst keeps a store pending at reset from committing.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wd_lanes[8*i +: 8];
      end
    end
  end

  assign bus.Mout     = mout_q;
  assign bus.stall    = stall_c;
  assign bus.misalign = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected results queued at request time, checked in DONE.
module tb_dmem_responder;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic [31:0] mout;
    logic        mis;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;
  exp_t sb[$];

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle_inputs();
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.fnc3     = '0;
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns just after the DONE->IDLE edge.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f,
                        input logic [31:0] em, input logic emis, input string name);
    exp_t e;
    int   nst;
    bit   done;
    e.mout = em; e.mis = emis; e.name = name;
    sb.push_back(e);
    bus.memRead = rd; bus.memWrite = wr; bus.addr = a; bus.wdata = wd; bus.fnc3 = f;
    @(negedge clk);
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL %s stall_on_req: got %b want 1", name, bus.stall);
    end
    vectors++;
    if (bus.misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL %s misalign_before_done: got %b want 0", name, bus.misalign);
    end
    nst = 1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) nst++;
      else done = 1;
    end
    last_done_cyc = cyc;
    e = sb.pop_front();
    vectors++;
    if (!done || nst != int'(LAT + 1)) begin
      miscompares++;
      $display("FAIL %s stall_cycles: got %0d (done=%0b) want %0d", e.name, nst, done, LAT + 1);
    end
    vectors++;
    if (bus.Mout !== e.mout) begin
      miscompares++;
      $display("FAIL %s Mout: got %h want %h", e.name, bus.Mout, e.mout);
    end
    vectors++;
    if (bus.misalign !== e.mis) begin
      miscompares++;
      $display("FAIL %s misalign: got %b want %b", e.name, bus.misalign, e.mis);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.memRead = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.Mout !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_Mout: got %h want 00000000", bus.Mout);
    end
    vectors++;
    if (bus.misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_misalign: got %b want 0", bus.misalign);
    end
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word();
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, "SW_0x10");
    access(1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, "LW_0x10");
  endtask

  task automatic test_byte();
    access(1'b0, 1'b1, 32'h0, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, "SW_0x0_zero");
    access(1'b0, 1'b1, 32'h3, 32'h80,       3'b000, 32'hDEADBEEF, 1'b0, "SB_0x3");
    access(1'b1, 1'b0, 32'h0, 32'h0,        3'b010, 32'h80000000, 1'b0, "LW_0x0");
    access(1'b1, 1'b0, 32'h3, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, "LB_0x3");
    access(1'b1, 1'b0, 32'h3, 32'h0,        3'b100, 32'h00000080, 1'b0, "LBU_0x3");
    access(1'b1, 1'b0, 32'h2, 32'h0,        3'b001, 32'hFFFF8000, 1'b0, "LH_0x2");
    access(1'b1, 1'b0, 32'h2, 32'h0,        3'b101, 32'h00008000, 1'b0, "LHU_0x2");
    access(1'b1, 1'b0, 32'h0, 32'h0,        3'b000, 32'h00000000, 1'b0, "LB_0x0");
    access(1'b0, 1'b1, 32'h0, 32'hFFFF1234, 3'b001, 32'h00000000, 1'b0, "SH_0x0");
    access(1'b1, 1'b0, 32'h0, 32'h0,        3'b010, 32'h80001234, 1'b0, "LW_0x0_after_SH");
    access(1'b1, 1'b0, 32'h1, 32'h0,        3'b100, 32'h00000012, 1'b0, "LBU_0x1");
  endtask

  task automatic test_misalign();
    access(1'b1, 1'b0, 32'h12, 32'h0,    3'b010, 32'h0,        1'b1, "LW_0x12_mis");
    access(1'b0, 1'b1, 32'h11, 32'h1234, 3'b001, 32'h0,        1'b1, "SH_0x11_mis");
    access(1'b1, 1'b0, 32'h10, 32'h0,    3'b010, 32'hDEADBEEF, 1'b0, "LW_0x10_intact");
    access(1'b1, 1'b0, 32'h13, 32'h0,    3'b001, 32'h0,        1'b1, "LH_0x13_mis");
    access(1'b1, 1'b0, 32'h11, 32'h0,    3'b101, 32'h0,        1'b1, "LHU_0x11_mis");
    access(1'b1, 1'b0, 32'h10, 32'h0,    3'b011, 32'h0,        1'b0, "L_fnc011");
    access(1'b0, 1'b1, 32'h10, 32'h0,    3'b011, 32'h0,        1'b0, "S_fnc011");
    access(1'b1, 1'b0, 32'h10, 32'h0,    3'b010, 32'hDEADBEEF, 1'b0, "LW_0x10_after_bad_store");
  endtask

  task automatic test_reset_mid();
    access(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 3'b010, 32'hDEADBEEF, 1'b0, "SW_0x20_old");
    bus.memWrite = 1'b1; bus.addr = 32'h20; bus.wdata = 32'h55AA55AA; bus.fnc3 = 3'b010;
    repeat (LAT) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got %b want 0", bus.stall);
    end
    vectors++;
    if (bus.Mout !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_Mout: got %h want 00000000", bus.Mout);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h0BADF00D, 1'b0, "LW_0x20_after_abort");
  endtask

  task automatic test_wrap();
    access(1'b0, 1'b1, 32'h1000,     32'h1,  3'b010, 32'h0BADF00D, 1'b0, "SW_0x1000");
    access(1'b1, 1'b0, 32'h0,        32'h0,  3'b010, 32'h00000001, 1'b0, "LW_0x0_wrap");
    access(1'b1, 1'b1, 32'h4,        32'h77, 3'b010, 32'h00000001, 1'b0, "RW_both_is_store");
    access(1'b1, 1'b0, 32'hFFFFF004, 32'h0,  3'b010, 32'h00000077, 1'b0, "LW_high_addr");
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    access(1'b1, 1'b0, 32'h4,  32'h0, 3'b010, 32'h00000077, 1'b0, "B2B_0");
    access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, "B2B_1");
    access(1'b1, 1'b0, 32'h0,  32'h0, 3'b100, 32'h00000001, 1'b0, "B2B_2");
    vectors++;
    if (last_done_cyc - c0 != int'(3 * LAT + 5)) begin
      miscompares++;
      $display("FAIL b2b_throughput: got %0d cycles want %0d", last_done_cyc - c0, 3 * LAT + 5);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_word();
    test_byte();
    test_misalign();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
